// File: rtl/alu_regfile_ctrl.sv
// alu_regfile_ctrl: operand register file and 3-cycle issue controller for a
// combinational ALU. Instructions (rd = rs1 op rs2) are accepted over a
// valid/ready handshake, operands are registered into the ALU, and the ALU
// result is written back to rd two edges after acceptance along with sticky
// carry/zero flags. A host load port preloads registers while idle, and a
// debug port reads any register combinationally.
// Optional feature macro: OP_COUNT_EN adds retired_cnt[15:0], a wrapping
// count of write-backs.
module alu_regfile_ctrl #(
    parameter int WIDTH = 8,
    parameter int REGS  = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_Y,
    input  logic             alu_c,
    input  logic             alu_zero,
`ifdef OP_COUNT_EN
    output logic [15:0]      retired_cnt,
`endif
    output logic             wb_valid,
    output logic [AW-1:0]    wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] regs_reg [REGS];
    logic [AW-1:0]    rd_reg;

    // Both register write sources are gated by FSM state, so at most one
    // fires per edge: host loads only in IDLE, write-back only in WB.
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Select the register-file write source for this cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state_reg == S_IDLE && ld_en) begin
            wr_en   = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end else if (state_reg == S_WB) begin
            wr_en   = 1'b1;
            wr_addr = rd_reg;
            wr_data = alu_Y;
        end
    end

    // Register file storage; cleared by reset so every register reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    // Issue FSM: accept -> EXEC (ALU settles) -> WB (capture result/flags).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            rd_reg     <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // A host load in the same cycle wins; instr_ready is low then.
                    if (!ld_en && instr_valid) begin
                        alu_A      <= regs_reg[instr_rs1];
                        alu_B      <= regs_reg[instr_rs2];
                        alu_opcode <= instr_op;
                        rd_reg     <= instr_rd;
                        state_reg  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_reg <= S_WB;
                end
                S_WB: begin
                    carry_flag <= alu_c;
                    zero_flag  <= alu_zero;
                    wb_valid   <= 1'b1;
                    wb_rd      <= rd_reg;
                    wb_data    <= alu_Y;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OP_COUNT_EN
    // Retired-instruction counter, bumped on every write-back; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (state_reg == S_WB) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end
`endif

    assign instr_ready = rst_n && (state_reg == S_IDLE) && !ld_en;
    assign busy        = (state_reg != S_IDLE);
    assign dbg_data    = regs_reg[dbg_addr];

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Directed testbench for alu_regfile_ctrl with a small behavioural ALU on the
// ALU-facing ports. Inputs change 1ns after each rising edge; outputs are
// sampled at the same point.
module tb_alu_regfile_ctrl;

    localparam int WIDTH = 8;
    localparam int REGS  = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_op;
    logic [AW-1:0]    instr_rd;
    logic [AW-1:0]    instr_rs1;
    logic [AW-1:0]    instr_rs2;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_Y;
    logic             alu_c;
    logic             alu_zero;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             carry_flag;
    logic             zero_flag;
    logic             busy;
`ifdef OP_COUNT_EN
    logic [15:0]      retired_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_regfile_ctrl #(.WIDTH(WIDTH), .REGS(REGS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .alu_A       (alu_A),
        .alu_B       (alu_B),
        .alu_opcode  (alu_opcode),
        .alu_Y       (alu_Y),
        .alu_c       (alu_c),
        .alu_zero    (alu_zero),
`ifdef OP_COUNT_EN
        .retired_cnt (retired_cnt),
`endif
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .busy        (busy)
    );

    // Behavioural combinational ALU: ADD, SUB (c = borrow), AND, OR, XOR.
    always_comb begin
        logic [WIDTH:0] t;
        t = '0;
        case (alu_opcode)
            3'b000:  t = {1'b0, alu_A} + {1'b0, alu_B};
            3'b001:  t = {1'b0, alu_A} - {1'b0, alu_B};
            3'b010:  t = {1'b0, alu_A & alu_B};
            3'b011:  t = {1'b0, alu_A | alu_B};
            3'b100:  t = {1'b0, alu_A ^ alu_B};
            default: t = '0;
        endcase
        alu_Y    = t[WIDTH-1:0];
        alu_c    = t[WIDTH];
        alu_zero = (t[WIDTH-1:0] == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        tick();
        tick();
        checks++;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", instr_ready); end
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL reset_busy_wb got %b%b want 00", busy, wb_valid); end
        checks++;
        if (alu_A !== 8'h00 || alu_B !== 8'h00 || alu_opcode !== 3'b000) begin
            errors++; $display("FAIL reset_alu got A=%h B=%h op=%b want 0", alu_A, alu_B, alu_opcode);
        end
        checks++;
        if (carry_flag !== 1'b0 || zero_flag !== 1'b0 || wb_data !== 8'h00 || wb_rd !== 3'd0) begin
            errors++; $display("FAIL reset_flags got c=%b z=%b wb=%h rd=%0d want 0", carry_flag, zero_flag, wb_data, wb_rd);
        end
        for (int i = 0; i < REGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            checks++;
            if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h want 00", i, dbg_data); end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", instr_ready); end
    endtask

    task automatic test_add();
        load(3'd1, 8'd254);
        load(3'd2, 8'd6);
        issue(3'b000, 3'd3, 3'd1, 3'd2);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", instr_ready); end
        tick();                         // accept edge N
        instr_valid = 1'b0;
        checks++;
        if (alu_A !== 8'd254 || alu_B !== 8'd6 || alu_opcode !== 3'b000 || busy !== 1'b1) begin
            errors++; $display("FAIL add_operands got A=%0d B=%0d op=%b busy=%b want 254 6 000 1", alu_A, alu_B, alu_opcode, busy);
        end
        tick();                         // edge N+1
        checks++;
        if (wb_valid !== 1'b0 || carry_flag !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL add_exec got wb=%b c=%b busy=%b want 0 0 1", wb_valid, carry_flag, busy);
        end
        tick();                         // write-back edge N+2
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 8'd4) begin
            errors++; $display("FAIL add_wb got v=%b rd=%0d data=%0d want 1 3 4", wb_valid, wb_rd, wb_data);
        end
        checks++;
        if (carry_flag !== 1'b1 || zero_flag !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL add_flags got c=%b z=%b busy=%b want 1 0 0", carry_flag, zero_flag, busy);
        end
        dbg_addr = 3'd3;
        #1;
        checks++;
        if (dbg_data !== 8'd4) begin errors++; $display("FAIL add_dbg_r3 got %0d want 4", dbg_data); end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_wb_pulse got %b want 0", wb_valid); end
    endtask

    task automatic test_sub_zero();
        load(3'd5, 8'd100);
        load(3'd4, 8'd77);
        issue(3'b001, 3'd4, 3'd5, 3'd5);
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 3'd4 || wb_data !== 8'd0) begin
            errors++; $display("FAIL sub_wb got v=%b rd=%0d data=%0d want 1 4 0", wb_valid, wb_rd, wb_data);
        end
        checks++;
        if (zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            errors++; $display("FAIL sub_flags got z=%b c=%b want 1 0", zero_flag, carry_flag);
        end
        dbg_addr = 3'd4;
        #1;
        checks++;
        if (dbg_data !== 8'd0) begin errors++; $display("FAIL sub_dbg_r4 got %0d want 0", dbg_data); end
        tick();
    endtask

    task automatic test_ld_priority();
        issue(3'b010, 3'd7, 3'd6, 3'd6);
        ld_en = 1'b1; ld_addr = 3'd6; ld_data = 8'h5A;
        #1;
        checks++;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL ldpri_ready got %b want 0", instr_ready); end
        tick();
        ld_en = 1'b0;
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 8'h5A || busy !== 1'b0) begin
            errors++; $display("FAIL ldpri_load got r6=%h busy=%b want 5a 0", dbg_data, busy);
        end
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL ldpri_ready_next got %b want 1", instr_ready); end
        tick();                         // accept
        instr_valid = 1'b0;
        checks++;
        if (alu_A !== 8'h5A || alu_B !== 8'h5A || busy !== 1'b1) begin
            errors++; $display("FAIL ldpri_accept got A=%h B=%h busy=%b want 5a 5a 1", alu_A, alu_B, busy);
        end
        // Host load while busy must be ignored.
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'hFF;
        tick();
        ld_en = 1'b0;
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 8'd254) begin errors++; $display("FAIL ld_busy_ignored got r1=%0d want 254", dbg_data); end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 3'd7 || wb_data !== 8'h5A) begin
            errors++; $display("FAIL ldpri_wb got v=%b rd=%0d data=%h want 1 7 5a", wb_valid, wb_rd, wb_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops   [3];
        logic [2:0]  rds   [3];
        logic [2:0]  rs1s  [3];
        logic [2:0]  rs2s  [3];
        logic [7:0]  exps  [3];
        int k;
`ifdef OP_COUNT_EN
        logic [15:0] cnt0;
        cnt0 = retired_cnt;
`endif
        ops[0] = 3'b011; rds[0] = 3'd0; rs1s[0] = 3'd1; rs2s[0] = 3'd2; exps[0] = 8'hFE; // FE | 06
        ops[1] = 3'b000; rds[1] = 3'd7; rs1s[1] = 3'd3; rs2s[1] = 3'd3; exps[1] = 8'h08; // 4 + 4
        ops[2] = 3'b100; rds[2] = 3'd2; rs1s[2] = 3'd0; rs2s[2] = 3'd7; exps[2] = 8'hF6; // FE ^ 08
        k = 0;
        issue(ops[0], rds[0], rs1s[0], rs2s[0]);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (instr_ready !== (i % 3 == 0)) begin
                errors++; $display("FAIL b2b_ready edge %0d got %b want %b", i, instr_ready, (i % 3 == 0));
            end
            tick();
            checks++;
            if (busy !== (i % 3 != 2) || wb_valid !== (i % 3 == 2)) begin
                errors++; $display("FAIL b2b_state edge %0d got busy=%b wb=%b want %b %b", i, busy, wb_valid, (i % 3 != 2), (i % 3 == 2));
            end
            if (i % 3 == 2) begin
                checks++;
                if (wb_data !== exps[k] || wb_rd !== rds[k]) begin
                    errors++; $display("FAIL b2b_wb%0d got rd=%0d data=%h want %0d %h", k, wb_rd, wb_data, rds[k], exps[k]);
                end
`ifdef OP_COUNT_EN
                checks++;
                if (retired_cnt !== cnt0 + 16'(k + 1)) begin
                    errors++; $display("FAIL retired_cnt got %h want %h", retired_cnt, cnt0 + 16'(k + 1));
                end
`endif
                k++;
                if (k < 3) issue(ops[k], rds[k], rs1s[k], rs2s[k]);
            end
        end
        instr_valid = 1'b0;
        dbg_addr = 3'd2;
        #1;
        checks++;
        if (dbg_data !== 8'hF6) begin errors++; $display("FAIL b2b_dbg_r2 got %h want f6", dbg_data); end
    endtask

    task automatic test_reset_mid();
        issue(3'b000, 3'd5, 3'd1, 3'd2);
        tick();                         // accepted, now in EXEC
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || instr_ready !== 1'b0 || alu_A !== 8'h00) begin
            errors++; $display("FAIL rstmid_async got busy=%b rdy=%b A=%h want 0 0 00", busy, instr_ready, alu_A);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_wb cycle %0d got %b want 0", i, wb_valid); end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
            errors++; $display("FAIL rstmid_after got busy=%b wb=%b c=%b z=%b want 0", busy, wb_valid, carry_flag, zero_flag);
        end
`ifdef OP_COUNT_EN
        checks++;
        if (retired_cnt !== 16'h0000) begin errors++; $display("FAIL rstmid_cnt got %h want 0000", retired_cnt); end
`endif
        for (int i = 0; i < REGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            checks++;
            if (dbg_data !== 8'h00) begin errors++; $display("FAIL rstmid_reg%0d got %h want 00", i, dbg_data); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_ld_priority();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
